// File: rtl/ber_test_sequencer.sv
// BER run sequencer: checker reset, align wait, settle, windowed error count.
// Define BER_SEQ_RELOCK_EN to relock and resume on lock loss (adds relock_cnt).
module ber_test_sequencer #(
  parameter int WIN_W      = 32,
  parameter int RST_CYC    = 16,
  parameter int SETTLE_CYC = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [WIN_W-1:0] window_len,
  input  logic [15:0]      align_timeout,
  input  logic             aligned,
  input  logic [6:0]       err_inc,
  input  logic             err_flag,
  output logic             checker_rst,
  output logic             busy,
  output logic             done,
  output logic [2:0]       state,
  output logic [39:0]      tot_errs,
  output logic [31:0]      err_words,
  output logic [WIN_W-1:0] window_cnt,
  output logic             timeout_err,
  output logic             lost_lock
`ifdef BER_SEQ_RELOCK_EN
  ,
  output logic [7:0]       relock_cnt
`endif
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RST    = 3'd1,
    S_WAIT   = 3'd2,
    S_SETTLE = 3'd3,
    S_MEAS   = 3'd4,
    S_DONE   = 3'd5
  } st_e;

  st_e              state_q, state_d;
  logic [31:0]      cnt_q, cnt_d;
  logic             chk_rst_q, chk_rst_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [39:0]      tot_errs_q, tot_errs_d;
  logic [31:0]      err_words_q, err_words_d;
  logic [WIN_W-1:0] window_cnt_q, window_cnt_d;
  logic             timeout_q, timeout_d;
  logic             lost_q, lost_d;
`ifdef BER_SEQ_RELOCK_EN
  logic [7:0]       relock_q, relock_d;
`endif

  logic [40:0]      tot_sum;
  logic [39:0]      tot_sat;
  logic [31:0]      words_sat;
  logic [WIN_W-1:0] wcnt_inc;
  logic             win_end;
  logic             tmo_hit;

  always_comb begin
    tot_sum   = {1'b0, tot_errs_q} + {34'd0, err_inc};
    tot_sat   = tot_sum[40] ? '1 : tot_sum[39:0];
    words_sat = (&err_words_q) ? err_words_q
                               : err_words_q + {31'd0, err_flag};
    wcnt_inc  = window_cnt_q + 1'b1;
    win_end   = (window_len != '0) && (wcnt_inc == window_len);
    tmo_hit   = (align_timeout != 16'd0) &&
                (cnt_q + 32'd1 == {16'd0, align_timeout});
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    chk_rst_d    = chk_rst_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    tot_errs_d   = tot_errs_q;
    err_words_d  = err_words_q;
    window_cnt_d = window_cnt_q;
    timeout_d    = timeout_q;
    lost_d       = lost_q;
`ifdef BER_SEQ_RELOCK_EN
    relock_d     = relock_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d      = S_RST;
          cnt_d        = '0;
          chk_rst_d    = 1'b1;
          busy_d       = 1'b1;
          tot_errs_d   = '0;
          err_words_d  = '0;
          window_cnt_d = '0;
          timeout_d    = 1'b0;
          lost_d       = 1'b0;
`ifdef BER_SEQ_RELOCK_EN
          relock_d     = '0;
`endif
        end
      end
      S_RST: begin
        if (cnt_q == 32'(RST_CYC - 1)) begin
          state_d   = S_WAIT;
          cnt_d     = '0;
          chk_rst_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_WAIT: begin
        if (aligned) begin
          state_d = S_SETTLE;
          cnt_d   = '0;
        end else if (tmo_hit) begin
          state_d   = S_DONE;
          timeout_d = 1'b1;
          done_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_SETTLE: begin
        // Lock must hold for the whole settle period.
        if (!aligned) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end else if (cnt_q == 32'(SETTLE_CYC - 1)) begin
          state_d = S_MEAS;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_MEAS: begin
        tot_errs_d   = tot_sat;
        err_words_d  = words_sat;
        window_cnt_d = wcnt_inc;
        if (!aligned) lost_d = 1'b1;
        // A full window wins over a coincident lock loss.
        if (win_end) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else if (!aligned) begin
`ifdef BER_SEQ_RELOCK_EN
          state_d   = S_RST;
          cnt_d     = '0;
          chk_rst_d = 1'b1;
          if (relock_q != 8'hFF) relock_d = relock_q + 8'd1;
`else
          state_d = S_DONE;
          done_d  = 1'b1;
`endif
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d   = S_IDLE;
        busy_d    = 1'b0;
        chk_rst_d = 1'b0;
      end
    endcase

    if (abort) begin
      state_d      = S_IDLE;
      cnt_d        = '0;
      chk_rst_d    = 1'b0;
      busy_d       = 1'b0;
      done_d       = 1'b0;
      tot_errs_d   = tot_errs_q;
      err_words_d  = err_words_q;
      window_cnt_d = window_cnt_q;
      timeout_d    = timeout_q;
      lost_d       = lost_q;
`ifdef BER_SEQ_RELOCK_EN
      relock_d     = relock_q;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      chk_rst_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      tot_errs_q   <= '0;
      err_words_q  <= '0;
      window_cnt_q <= '0;
      timeout_q    <= 1'b0;
      lost_q       <= 1'b0;
`ifdef BER_SEQ_RELOCK_EN
      relock_q     <= '0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      chk_rst_q    <= chk_rst_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      tot_errs_q   <= tot_errs_d;
      err_words_q  <= err_words_d;
      window_cnt_q <= window_cnt_d;
      timeout_q    <= timeout_d;
      lost_q       <= lost_d;
`ifdef BER_SEQ_RELOCK_EN
      relock_q     <= relock_d;
`endif
    end
  end

  assign checker_rst = chk_rst_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign state       = state_q;
  assign tot_errs    = tot_errs_q;
  assign err_words   = err_words_q;
  assign window_cnt  = window_cnt_q;
  assign timeout_err = timeout_q;
  assign lost_lock   = lost_q;
`ifdef BER_SEQ_RELOCK_EN
  assign relock_cnt  = relock_q;
`endif

endmodule

// File: doc/ber_test_sequencer.md
BER_TEST_SEQUENCER -- requirements
Module: ber_test_sequencer

Interface
REQ-001 SHALL have parameter WIN_W, default 32: width of window length and window counter.
REQ-002 SHALL have parameter RST_CYC, default 16: cycles checker_rst is held asserted.
REQ-003 SHALL have parameter SETTLE_CYC, default 8: cycles waited after alignment before measuring.
REQ-004 SHALL have port clk, input, 1: single clock, all logic on rising edge; reset is synchronous and active-high.
REQ-005 SHALL have port reset, input, 1: synchronous active-high reset.
REQ-006 SHALL have port start, input, 1: request a BER run.
REQ-007 SHALL have port abort, input, 1: cancel a run.
REQ-008 SHALL have port window_len, input, WIN_W: measurement length in cycles; 0 means run until abort.
REQ-009 SHALL have port align_timeout, input, 16: maximum WAIT_ALIGN cycles; 0 disables the timeout.
REQ-010 SHALL have port aligned, input, 1: lock indication from the aligner.
REQ-011 SHALL have port err_inc, input, 7: errored bits in the current 64-bit word, range 0..64.
REQ-012 SHALL have port err_flag, input, 1: current word has at least one error.
REQ-013 SHALL have port checker_rst, output, 1: reset to the aligner/checker.
REQ-014 SHALL have ports busy (output, 1) and done (output, 1): busy is high while not IDLE; done is a one-cycle completion pulse.
REQ-015 SHALL have port state, output, 3: encoding IDLE=0, RST_CHK=1, WAIT_ALIGN=2, SETTLE=3, MEASURE=4, DONE=5.
REQ-016 SHALL have ports tot_errs (output, 40), err_words (output, 32) and window_cnt (output, WIN_W).
REQ-017 SHALL have ports timeout_err (output, 1) and lost_lock (output, 1): sticky status for the current run.

Function
REQ-018 SHALL accept start only in IDLE; start is ignored in all other states.
- On acceptance: clear tot_errs, err_words, window_cnt, timeout_err and lost_lock.
- Enter RST_CHK on the next cycle.
REQ-019 In RST_CHK, checker_rst SHALL be high for exactly RST_CYC cycles; then the block SHALL enter WAIT_ALIGN.
REQ-020 WAIT_ALIGN behaviour SHALL be:
- aligned=1 -> enter SETTLE.
- align_timeout>0 and align_timeout cycles elapsed without aligned -> set timeout_err and enter DONE.
REQ-021 SETTLE SHALL last SETTLE_CYC cycles; if aligned drops during SETTLE, the block SHALL return to WAIT_ALIGN with the timeout counter cleared.
REQ-022 Each MEASURE cycle SHALL apply these updates:
- tot_errs += zero-extended err_inc, saturating at all-ones.
- err_words += err_flag, saturating.
- window_cnt += 1.
REQ-023 MEASURE SHALL end after exactly window_len accumulated cycles (window_cnt==window_len), then enter DONE; window_len=0 SHALL never end on count.
REQ-024 If aligned=0 in MEASURE, that cycle's errors SHALL still be counted and lost_lock set; the next state SHALL follow REQ-035/036.
REQ-025 If lock loss and the final window cycle coincide, the window SHALL be treated as complete: enter DONE with lost_lock=1.
REQ-026 DONE SHALL last one cycle with done=1, then return to IDLE; counters and status SHALL hold until the next accepted start.
REQ-027 abort SHALL have priority over all transitions: any state goes to IDLE next cycle, checker_rst=0, done not pulsed, counters held.
REQ-028 start and abort asserted together in IDLE SHALL result in abort winning: no run starts.
REQ-029 All outputs SHALL be registered.

Reset
REQ-030 reset SHALL force state=IDLE and drive all outputs to 0 on the next edge.
REQ-031 reset asserted mid-run SHALL abandon the run without a done pulse; reset has priority over abort and start.

Configuration
REQ-032 The macro BER_SEQ_RELOCK_EN SHALL select the lock-loss behaviour in MEASURE.
REQ-033 With BER_SEQ_RELOCK_EN defined, the block SHALL add output relock_cnt, 8 bits, saturating, cleared on start.
REQ-034 relock_cnt SHALL count relock attempts.
REQ-035 With BER_SEQ_RELOCK_EN defined, lock loss in MEASURE SHALL:
- increment relock_cnt;
- re-enter RST_CHK with tot_errs, err_words and window_cnt retained;
- resume accumulation in MEASURE after SETTLE.
REQ-036 Without BER_SEQ_RELOCK_EN, lock loss in MEASURE SHALL end the run in DONE, and the relock_cnt port SHALL be absent.

Verification
REQ-037 The bench SHALL cover these scenarios:
- Nominal run: start, aligned high 5 cycles after checker_rst falls, window_len=100, err_inc=1 every 10th cycle -> checker_rst high 16 cycles, tot_errs=10, err_words=10, window_cnt=100, one done pulse, timeout_err=0.
- Timeout: align_timeout=50, aligned held 0 -> DONE exactly 50 cycles after WAIT_ALIGN entry, timeout_err=1, tot_errs=0.
- Saturation: preload tot_errs to 2^40-10 via force, err_inc=64 -> tot_errs stays at 2^40-1.
- Abort: abort in MEASURE at window_cnt=37 -> IDLE next cycle, no done, window_cnt=37; start ignored in MEASURE.
- Lock loss without macro: aligned drops at window_cnt=20 -> lost_lock=1, DONE, window_cnt=21.
- Lock loss with macro: same stimulus -> relock_cnt=1, second RST_CHK, final window_cnt=window_len.
